row_skew_feeder: RTL

//  Downstream read sequencer for row_buffer. On start, walks one skewed bank (Q or S)
//  of the row buffer, reads its 2*MATRIX_SIZE-1 staggered rows in address order and

---
 rtl/row_skew_feeder.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/row_skew_feeder.sv
// ---------------------------------------------------------------------------
// row_skew_feeder
// Read sequencer between row_buffer and the systolic-array row input.
// On start it reads the 2*N-1 staggered rows of one bank (Q or S) in address
// order. It then appends FLUSH_ZEROS all-zero rows and streams everything out
// with valid/ready. A 2-entry output FIFO absorbs the buffer's 1-cycle read
// latency. Issue is credit-gated, so back-pressure never drops or repeats a row.
//
// Ports
//   clk, reset_n    clock, asynchronous active-low reset
//   start, sel      1-cycle request (sampled in IDLE) and bank select (0=Q, 1=S)
//   busy, done      sequence in progress / 1-cycle completion pulse
//   buf_read_en     row_buffer read strobe
//   buf_read_addr   bank-relative row address 0..2N-2
//   buf_sel         latched bank select
//   buf_read_data   row_buffer data, valid the cycle after buf_read_en
//   out_valid, out_ready, out_data, out_last   output row stream
// ---------------------------------------------------------------------------
module row_skew_feeder #(
    parameter int INPUT_WIDTH = 8,
    parameter int MATRIX_SIZE = 3,
    parameter int ADDR_WIDTH  = $clog2(MATRIX_SIZE**2 << 2),
    parameter int FLUSH_ZEROS = MATRIX_SIZE - 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               sel,
    output logic                               busy,
    output logic                               done,
    output logic                               buf_read_en,
    output logic [ADDR_WIDTH-1:0]              buf_read_addr,
    output logic                               buf_sel,
    input  logic [MATRIX_SIZE*INPUT_WIDTH-1:0] buf_read_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [MATRIX_SIZE*INPUT_WIDTH-1:0] out_data,
    output logic                               out_last
);

    localparam int ROW_W = MATRIX_SIZE * INPUT_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(2 * MATRIX_SIZE - 2);
    localparam int FLUSH_CW = $clog2(FLUSH_ZEROS + 2);
    localparam logic [FLUSH_CW-1:0] FLUSH_LAST =
        FLUSH_CW'((FLUSH_ZEROS > 0) ? FLUSH_ZEROS - 1 : 0);
    // With no flush rows the last data row carries out_last.
    localparam bit DATA_ENDS = (FLUSH_ZEROS == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_FLUSH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_cnt_reg;
    logic [FLUSH_CW-1:0]     flush_cnt_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    sel_reg;
    logic                    inflight_reg;
    logic                    inflight_last_reg;

    // FIFO: head_reg is the visible entry, tail_reg the one behind it.
    logic [1:0]              occ_reg;
    logic [ROW_W-1:0]        head_reg;
    logic [ROW_W-1:0]        tail_reg;
    logic                    head_last_reg;
    logic                    tail_last_reg;

    logic                    pop;
    logic                    issue;
    logic                    flush_push;
    logic                    push;
    logic                    push_last;
    logic [ROW_W-1:0]        push_data;
    logic                    drain_empty;

    assign pop = (occ_reg != 2'd0) && out_ready;

    // The credit check has to see this cycle's pop. A row leaving now frees
    // the slot for the read issued now. So the strobe is decoded from the
    // registered state rather than registered itself.
    assign issue = (state_reg == S_READ) &&
                   (({1'b0, occ_reg} + {2'b0, inflight_reg}) < (3'd2 + {2'b0, pop}));

    // A zero row waits until the final read has landed. This keeps the pushes
    // in order and limits pushes to one per cycle.
    assign flush_push = (state_reg == S_FLUSH) && !inflight_reg &&
                        ((occ_reg != 2'd2) || pop);

    assign push      = inflight_reg | flush_push;
    assign push_data = inflight_reg ? buf_read_data : '0;
    assign push_last = inflight_reg ? (inflight_last_reg && DATA_ENDS)
                                    : (flush_cnt_reg == FLUSH_LAST);

    // Done fires the cycle after the final handshake. Leave DRAIN when the
    // FIFO is empty, or is about to empty through this cycle's pop.
    assign drain_empty = !inflight_reg &&
                         ((occ_reg == 2'd0) || ((occ_reg == 2'd1) && pop));

    assign busy          = busy_reg;
    assign done          = done_reg;
    assign buf_sel       = sel_reg;
    assign buf_read_en   = issue;
    assign buf_read_addr = issue ? addr_cnt_reg : '0;
    assign out_valid     = (occ_reg != 2'd0);
    assign out_data      = head_reg;
    assign out_last      = out_valid && head_last_reg;

    // Sequencer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= S_IDLE;
            addr_cnt_reg      <= '0;
            flush_cnt_reg     <= '0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            sel_reg           <= 1'b0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            done_reg          <= 1'b0;
            inflight_reg      <= issue;
            inflight_last_reg <= issue && (addr_cnt_reg == LAST_ADDR);
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        sel_reg       <= sel;
                        addr_cnt_reg  <= '0;
                        flush_cnt_reg <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue) begin
                        addr_cnt_reg <= addr_cnt_reg + 1'b1;
                        if (addr_cnt_reg == LAST_ADDR) begin
                            state_reg <= DATA_ENDS ? S_DRAIN : S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (flush_push) begin
                        flush_cnt_reg <= flush_cnt_reg + 1'b1;
                        if (flush_cnt_reg == FLUSH_LAST) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_empty) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Output FIFO. Credit gating guarantees no push arrives when it is full.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_reg       <= 2'd0;
            head_reg      <= '0;
            tail_reg      <= '0;
            head_last_reg <= 1'b0;
            tail_last_reg <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_reg == 2'd0) begin
                        head_reg      <= push_data;
                        head_last_reg <= push_last;
                    end else begin
                        tail_reg      <= push_data;
                        tail_last_reg <= push_last;
                    end
                    occ_reg <= occ_reg + 2'd1;
                end
                2'b01: begin
                    if (occ_reg == 2'd2) begin
                        head_reg      <= tail_reg;
                        head_last_reg <= tail_last_reg;
                    end
                    occ_reg <= occ_reg - 2'd1;
                end
                2'b11: begin
                    if (occ_reg == 2'd1) begin
                        head_reg      <= push_data;
                        head_last_reg <= push_last;
                    end else begin
                        head_reg      <= tail_reg;
                        head_last_reg <= tail_last_reg;
                        tail_reg      <= push_data;
                        tail_last_reg <= push_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
